encoder_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single 3-bit-to-7-bit one-hot encoder between up to seven requesters.
- Each cycle in IDLE it picks one requester and drives the encoder's 3-bit code input, in binary or Gray coding to match the encoder's USE_GRAY setting.
- It also produces a registered 7-bit one-hot grant with the same mapping as the encoder: code 0 means no bit set, code k sets bit k-1.
- Holds a grant until the owner signals done, withdraws its request, or a hold timeout expires.

---
 rtl/encoder_rr_arbiter_if.sv | 23 ++
 rtl/encoder_rr_arbiter.sv | 125 ++++++++++++
 tb/tb_encoder_rr_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/encoder_rr_arbiter_if.sv
// Request/grant bundle between up to seven requesters and the encoder arbiter.
// Handshake: a requester keeps req[i] high to ask for the encoder. It owns the encoder
// while grant[i] is high. It gives the encoder back with a single-cycle done pulse or by
// dropping req[i]. A grant that is held too long is withdrawn with a timeout pulse.
interface encoder_rr_arbiter_if;
    logic [6:0] req;
    logic       done;
    logic [6:0] grant;
    logic [2:0] grant_code;
    logic       grant_valid;
    logic       timeout;
    logic       state_dbg;

    modport master (
        output req, done,
        input  grant, grant_code, grant_valid, timeout, state_dbg
    );

    modport slave (
        input  req, done,
        output grant, grant_code, grant_valid, timeout, state_dbg
    );
endinterface

// File: rtl/encoder_rr_arbiter.sv
// Round-robin arbiter that shares one 3-to-7 one-hot encoder between seven requesters.
// It drives the encoder code (binary or Gray) and a matching registered one-hot grant.
module encoder_rr_arbiter #(
    parameter bit USE_GRAY = 1'b0,
    parameter int MAX_HOLD = 15
) (
    input  logic clk,
    input  logic rst,
    encoder_rr_arbiter_if.slave bus
);
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

    state_t     r_state;
    logic [2:0] r_ptr;
    logic [2:0] r_owner;
    logic [7:0] r_hold;
    logic [6:0] r_grant;
    logic [2:0] r_code;
    logic       r_valid;
    logic       r_timeout;

    state_t     w_state_n;
    logic [2:0] w_ptr_n;
    logic [2:0] w_owner_n;
    logic [7:0] w_hold_n;
    logic [6:0] w_grant_n;
    logic [2:0] w_code_n;
    logic       w_valid_n;
    logic       w_timeout_n;
    logic       w_found;
    logic [2:0] w_sel;

    // Code presented to the encoder for requester idx (idx+1, optionally Gray coded).
    function automatic logic [2:0] f_code(input logic [2:0] idx);
        logic [2:0] b;
        b = idx + 3'd1;
        return USE_GRAY ? (b ^ (b >> 1)) : b;
    endfunction

    // First requester at or after r_ptr, wrapping modulo 7.
    always_comb begin
        logic [3:0] idx;
        w_found = 1'b0;
        w_sel   = 3'd0;
        idx     = 4'd0;
        for (int k = 0; k < 7; k++) begin
            idx = {1'b0, r_ptr} + 4'(k);
            if (idx >= 4'd7) idx = idx - 4'd7;
            if (!w_found && bus.req[idx[2:0]]) begin
                w_found = 1'b1;
                w_sel   = idx[2:0];
            end
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_ptr_n     = r_ptr;
        w_owner_n   = r_owner;
        w_hold_n    = r_hold;
        w_grant_n   = r_grant;
        w_code_n    = r_code;
        w_valid_n   = r_valid;
        w_timeout_n = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_n = ST_GRANT;
                    w_owner_n = w_sel;
                    w_hold_n  = 8'd1;
                    w_grant_n = 7'd1 << w_sel;
                    w_code_n  = f_code(w_sel);
                    w_valid_n = 1'b1;
                end
            end
            ST_GRANT: begin
                // done outranks withdrawal, which outranks the hold limit.
                if (bus.done || !bus.req[r_owner] || (r_hold == LP_MAX_HOLD)) begin
                    w_state_n   = ST_IDLE;
                    w_ptr_n     = (r_owner == 3'd6) ? 3'd0 : r_owner + 3'd1;
                    w_grant_n   = 7'd0;
                    w_code_n    = 3'd0;
                    w_valid_n   = 1'b0;
                    w_timeout_n = !bus.done && bus.req[r_owner];
                end else begin
                    w_hold_n = r_hold + 8'd1;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= 3'd0;
            r_owner   <= 3'd0;
            r_hold    <= 8'd0;
            r_grant   <= 7'd0;
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_ptr     <= w_ptr_n;
            r_owner   <= w_owner_n;
            r_hold    <= w_hold_n;
            r_grant   <= w_grant_n;
            r_code    <= w_code_n;
            r_valid   <= w_valid_n;
            r_timeout <= w_timeout_n;
        end
    end

    assign bus.grant       = r_grant;
    assign bus.grant_code  = r_code;
    assign bus.grant_valid = r_valid;
    assign bus.timeout     = r_timeout;
    assign bus.state_dbg   = r_state;
endmodule

// File: tb/tb_encoder_rr_arbiter.sv
// Bench for encoder_rr_arbiter: a binary instance (MAX_HOLD=4) and a Gray instance
// (MAX_HOLD=15) share one stimulus stream and are compared with a reference model.
module tb_encoder_rr_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [6:0] req;
  logic       done;

  encoder_rr_arbiter_if bus_b ();
  encoder_rr_arbiter_if bus_g ();

  assign bus_b.req  = req;
  assign bus_b.done = done;
  assign bus_g.req  = req;
  assign bus_g.done = done;

  encoder_rr_arbiter #(.USE_GRAY(1'b0), .MAX_HOLD(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));
  encoder_rr_arbiter #(.USE_GRAY(1'b1), .MAX_HOLD(15)) dut_g (.clk(clk), .rst(rst), .bus(bus_g));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: owner (-1 = none), round-robin pointer, cycles held, timeout pulse.
  int m_owner [2];
  int m_ptr   [2];
  int m_hold  [2];
  bit m_to    [2];
  int mh      [2] = '{4, 15};
  bit use_g   [2] = '{1'b0, 1'b1};
  int gray_tab[8] = '{0, 1, 3, 2, 6, 7, 5, 4};

  function automatic int exp_code(int k);
    if (m_owner[k] < 0) return 0;
    return use_g[k] ? gray_tab[m_owner[k] + 1] : m_owner[k] + 1;
  endfunction

  function automatic logic [6:0] exp_grant(int k);
    if (m_owner[k] < 0) return 7'd0;
    return 7'(1 << m_owner[k]);
  endfunction

  // Behavioural 3-to-7 encoder: code value (after Gray decode) v>0 lights bit v-1.
  function automatic logic [6:0] encoder(int k, logic [2:0] c);
    int v;
    v = int'(c);
    if (use_g[k]) begin
      for (int j = 0; j < 8; j++)
        if (gray_tab[j] == int'(c)) v = j;
    end
    if (v == 0) return 7'd0;
    return 7'(1 << (v - 1));
  endfunction

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      m_to[k] = 1'b0;
      if (rst) begin
        m_owner[k] = -1;
        m_ptr[k]   = 0;
        m_hold[k]  = 0;
      end else if (m_owner[k] < 0) begin
        for (int s = 0; s < 7; s++) begin
          if (m_owner[k] < 0 && req[(m_ptr[k] + s) % 7]) begin
            m_owner[k] = (m_ptr[k] + s) % 7;
            m_hold[k]  = 1;
          end
        end
      end else if (done || !req[m_owner[k]] || m_hold[k] == mh[k]) begin
        m_to[k]    = !done && req[m_owner[k]];
        m_ptr[k]   = (m_owner[k] + 1) % 7;
        m_owner[k] = -1;
      end else begin
        m_hold[k]++;
      end
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic read_out(int k, output logic [6:0] g, output logic [2:0] c,
                          output logic v, output logic t);
    if (k == 0) begin
      g = bus_b.grant; c = bus_b.grant_code; v = bus_b.grant_valid; t = bus_b.timeout;
    end else begin
      g = bus_g.grant; c = bus_g.grant_code; v = bus_g.grant_valid; t = bus_g.timeout;
    end
  endtask

  task automatic check_all();
    logic [6:0] g;
    logic [2:0] c;
    logic       v, t;
    for (int k = 0; k < 2; k++) begin
      read_out(k, g, c, v, t);
      chk($sformatf("grant%0d", k), 32'(g), 32'(exp_grant(k)));
      chk($sformatf("code%0d", k), 32'(c), 32'(exp_code(k)));
      chk($sformatf("valid%0d", k), 32'(v), 32'(m_owner[k] >= 0));
      chk($sformatf("timeout%0d", k), 32'(t), 32'(m_to[k]));
      chk($sformatf("enc_xchk%0d", k), 32'(encoder(k, c)), 32'(g));
      chk($sformatf("onehot%0d", k), 32'($countones(g) <= 1), 32'd1);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 7'd0; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_dir(string tag, int k, logic [6:0] eg, logic [2:0] ec, logic et);
    logic [6:0] g;
    logic [2:0] c;
    logic       v, t;
    read_out(k, g, c, v, t);
    chk({tag, "_grant"}, 32'(g), 32'(eg));
    chk({tag, "_code"}, 32'(c), 32'(ec));
    chk({tag, "_to"}, 32'(t), 32'(et));
  endtask

  initial begin
    logic [2:0] rr_idx [5];
    logic [2:0] rr_gray[5];
    rr_idx  = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0};
    rr_gray = '{3'b001, 3'b010, 3'b111, 3'b100, 3'b001};

    // Reset with all requests pending, then first grant to requester 0.
    rst = 1'b1; req = 7'h7f; done = 1'b0;
    tick();
    chk_dir("rst_b", 0, 7'd0, 3'd0, 1'b0);
    tick();
    chk_dir("rst_g", 1, 7'd0, 3'd0, 1'b0);
    rst = 1'b0;
    tick();
    chk_dir("first_b", 0, 7'h01, 3'b001, 1'b0);
    chk_dir("first_g", 1, 7'h01, 3'b001, 1'b0);

    // Round-robin over 1010101 with done three cycles into each grant.
    do_reset();
    req = 7'b1010101;
    tick();
    for (int n = 0; n < 5; n++) begin
      chk_dir($sformatf("rr%0d_b", n), 0, 7'(1 << rr_idx[n]), rr_idx[n] + 3'd1, 1'b0);
      chk_dir($sformatf("rr%0d_g", n), 1, 7'(1 << rr_idx[n]), rr_gray[n], 1'b0);
      tick();
      tick();
      done = 1'b1;
      tick();
      chk_dir($sformatf("rr%0d_idle", n), 0, 7'd0, 3'd0, 1'b0);
      done = 1'b0;
      tick();
    end

    // Wrap-around: ptr moved to 6 by serving requester 5, then 6 and 0 compete.
    do_reset();
    req = 7'h20;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0; req = 7'h41;
    tick();
    chk_dir("wrap6_g", 1, 7'h40, 3'b100, 1'b0);
    chk_dir("wrap6_b", 0, 7'h40, 3'b111, 1'b0);
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk_dir("wrap0_g", 1, 7'h01, 3'b001, 1'b0);

    // Timeout on the MAX_HOLD=4 instance, then search resumes from ptr=4.
    do_reset();
    req = 7'h08;
    for (int n = 0; n < 4; n++) begin
      tick();
      chk_dir($sformatf("hold%0d", n), 0, 7'h08, 3'd4, 1'b0);
    end
    tick();
    chk_dir("tmo", 0, 7'd0, 3'd0, 1'b1);
    req = 7'h18;
    tick();
    chk_dir("tmo_next", 0, 7'h10, 3'd5, 1'b0);

    // Withdrawal releases at the next edge without a timeout pulse.
    do_reset();
    req = 7'h04;
    tick();
    chk_dir("wd_grant", 0, 7'h04, 3'd3, 1'b0);
    req = 7'h00;
    tick();
    chk_dir("wd_rel", 0, 7'd0, 3'd0, 1'b0);
    chk_dir("wd_rel_g", 1, 7'd0, 3'd0, 1'b0);

    // Reset mid-grant: pointer returns to 0 so requester 5 beats 6.
    do_reset();
    req = 7'h20;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk_dir("rm_pre", 0, 7'h20, 3'd6, 1'b0);
    rst = 1'b1;
    tick();
    chk_dir("rm_drop", 0, 7'd0, 3'd0, 1'b0);
    rst = 1'b0; req = 7'h60;
    tick();
    chk_dir("rm_after", 0, 7'h20, 3'd6, 1'b0);

    // Random traffic: sticky requests, sparse done, rare resets.
    do_reset();
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) req = 7'($urandom_range(0, 127));
      done = ($urandom_range(0, 4) == 0);
      rst  = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; done = 1'b0; req = 7'd0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
